// File: rtl/gpio_pkg.sv
// Shared register map and bus-request bundle
// for the GPIO input capture block.
package gpio_pkg;

  localparam int REG_IDX_W = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t GPIO_DATA  = 2'd0;
  localparam reg_idx_t GPIO_RISE  = 2'd1;
  localparam reg_idx_t GPIO_FALL  = 2'd2;
  localparam reg_idx_t GPIO_IRQEN = 2'd3;

  typedef struct packed {
    logic     rd;
    logic     wr;
    reg_idx_t idx;
  } bus_req_t;

endpackage

// File: rtl/gpio_in_filter.sv
// One input pin: synchroniser, tick-sampled
// 3-deep history, debounced bit and edge pulses.
module gpio_in_filter (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pin,
  output logic data,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic [2:0] hist;
  logic       data_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      hist <= '0;
      data <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      if (tick) hist <= {hist[1:0], sync[1]};
      data <= data_nxt;
    end
  end

  // Disagreeing history holds the last settled value.
  always_comb begin
    data_nxt = data;
    unique case (1'b1)
      (hist == 3'b111): data_nxt = 1'b1;
      (hist == 3'b000): data_nxt = 1'b0;
      default:          data_nxt = data;
    endcase
  end

  assign rise = data_nxt & ~data;
  assign fall = ~data_nxt & data;

endmodule

// File: rtl/gpio_input_capture.sv
// Memory-mapped debounced GPIO input bank with
// sticky edge flags and a level interrupt.
module gpio_input_capture
  import gpio_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_8100,
  parameter int          DEBOUNCE_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             bus_valid_i,
  input  logic             bus_read_i,
  input  logic             bus_write_i,
  input  logic [31:0]      bus_addr_i,
  input  logic [31:0]      bus_data_i,
  output logic             bus_valid_o,
  output logic [31:0]      bus_data_o,
  output logic             irq_o
);

  localparam int CW = $clog2(DEBOUNCE_DIV);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_DIV - 1);

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rise_p;
  logic [WIDTH-1:0] fall_p;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] en_q;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [WIDTH-1:0] rd_val;
  logic             hit;
  bus_req_t         req;
  logic             unused_bits;

  assign tick  = (cnt == CNT_MAX);
  assign wmask = bus_data_i[WIDTH-1:0];
  assign unused_bits = ^{bus_addr_i[1:0], bus_data_i};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_filter u_flt (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .pin     (gpio_i[i]),
      .data    (data_q[i]),
      .rise    (rise_p[i]),
      .fall    (fall_p[i])
    );
  end

  // Read+write together is handled as a write.
  always_comb begin
    hit = bus_valid_i &&
      (bus_addr_i[31:4] == BASE_ADDR[31:4]);
    req.wr  = hit & bus_write_i;
    req.rd  = hit & bus_read_i & ~bus_write_i;
    req.idx = bus_addr_i[3:2];
  end

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    if (req.wr && req.idx == GPIO_RISE)
      rise_clr = wmask;
    if (req.wr && req.idx == GPIO_FALL)
      fall_clr = wmask;
  end

  always_comb begin
    rd_val = '0;
    unique case (req.idx)
      GPIO_DATA:  rd_val = data_q;
      GPIO_RISE:  rd_val = rise_q;
      GPIO_FALL:  rd_val = fall_q;
      GPIO_IRQEN: rd_val = en_q;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      en_q        <= '0;
      irq_o       <= 1'b0;
      bus_valid_o <= 1'b0;
      bus_data_o  <= '0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      // A new edge beats a same-cycle clear.
      rise_q <= (rise_q & ~rise_clr) | rise_p;
      fall_q <= (fall_q & ~fall_clr) | fall_p;
      if (req.wr && req.idx == GPIO_IRQEN)
        en_q <= wmask;
      irq_o       <= |((rise_q | fall_q) & en_q);
      bus_valid_o <= req.rd | req.wr;
      bus_data_o  <= req.rd ? 32'(rd_val) : '0;
    end
  end

endmodule

// File: tb/tb_gpio_input_capture.sv
// Randomised bench for gpio_input_capture against
// a settled-state register model.
module tb_gpio_input_capture;

  localparam logic [31:0] BASE = 32'h8100;
  localparam int SETTLE = 25;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  gpio = '0;
  logic        bus_valid = 1'b0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_data, m_rise, m_fall, m_en;

  gpio_input_capture #(
    .WIDTH        (8),
    .BASE_ADDR    (BASE),
    .DEBOUNCE_DIV (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .gpio_i      (gpio),
    .bus_valid_i (bus_valid),
    .bus_read_i  (bus_read),
    .bus_write_i (bus_write),
    .bus_addr_i  (bus_addr),
    .bus_data_i  (bus_wdata),
    .bus_valid_o (rsp_valid),
    .bus_data_o  (rsp_data),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic rd,
                        input logic wr,
                        input logic [31:0] addr,
                        input logic [31:0] data,
                        output logic v,
                        output logic [31:0] q);
    bus_valid = 1'b1;
    bus_read  = rd;
    bus_write = wr;
    bus_addr  = addr;
    bus_wdata = data;
    cyc(1);
    bus_valid = 1'b0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    v = rsp_valid;
    q = rsp_data;
  endtask

  function automatic logic [7:0] m_reg(input int off);
    case (off)
      0:  return m_data;
      4:  return m_rise;
      8:  return m_fall;
      default: return m_en;
    endcase
  endfunction

  task automatic rd_chk(input string tag, input int off);
    logic v;
    logic [31:0] q;
    bus_op(1'b1, 1'b0, BASE + off, '0, v, q);
    chk({tag, " vld"}, v, 1);
    chk(tag, q, {24'h0, m_reg(off)});
  endtask

  task automatic do_write(input int off,
                          input logic [31:0] d);
    logic v;
    logic [31:0] q;
    bus_op(1'b0, 1'b1, BASE + off, d, v, q);
    chk("wr vld", v, 1);
    chk("wr data", q, 0);
    case (off)
      4: m_rise &= ~d[7:0];
      8: m_fall &= ~d[7:0];
      12: m_en = d[7:0];
      default: ;
    endcase
  endtask

  task automatic set_pins(input logic [7:0] p);
    gpio = p;
    cyc(SETTLE);
    m_rise |= p & ~m_data;
    m_fall |= ~p & m_data;
    m_data = p;
  endtask

  task automatic check_all(input string tag);
    cyc(1);
    chk({tag, " irq"}, irq,
        |((m_rise | m_fall) & m_en));
    rd_chk({tag, " DATA"}, 0);
    rd_chk({tag, " RISE"}, 4);
    rd_chk({tag, " FALL"}, 8);
    rd_chk({tag, " IRQEN"}, 12);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    gpio = '0;
    cyc(2);
    reset_n = 1'b1;
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    m_en   = '0;
  endtask

  task automatic coll_setup();
    apply_reset();
    gpio = 8'h01;
    cyc(SETTLE);
    do_write(12, 32'h1);
    do_write(4, 32'hFF);
    cyc(1);
    chk("coll pre irq", irq, 0);
    gpio = 8'h00;
  endtask

  initial begin
    logic v;
    logic [31:0] q;
    int lat;
    bit found;

    // Reset held with pins toggling.
    for (int i = 0; i < 4; i++) begin
      gpio = 8'($urandom);
      cyc(3);
      chk("rst irq", irq, 0);
      chk("rst vld", rsp_valid, 0);
      chk("rst data", rsp_data, 0);
    end
    gpio = '0;
    reset_n = 1'b1;
    m_data = '0;
    m_rise = '0;
    m_fall = '0;
    m_en   = '0;
    cyc(1);
    for (int off = 0; off < 16; off += 4)
      rd_chk("post rst", off);

    // Debounce to 0x5A.
    gpio = 8'h5A;
    cyc(2 + 4 * 4);
    m_data = 8'h5A;
    m_rise = 8'h5A;
    rd_chk("deb DATA", 0);
    rd_chk("deb RISE", 4);
    rd_chk("deb FALL", 8);

    // Short glitch on pin 0.
    gpio = 8'h5B;
    cyc(3);
    gpio = 8'h5A;
    cyc(SETTLE);
    check_all("glitch");

    // W1C clears the only enabled flag.
    cyc(1);
    chk("w1c irq pre", irq, 0);
    do_write(12, 32'h02);
    cyc(1);
    chk("w1c irq on", irq, 1);
    do_write(4, 32'h02);
    cyc(1);
    chk("w1c irq off", irq, 0);
    rd_chk("w1c RISE", 4);
    chk("w1c model", {24'h0, m_rise}, 32'h58);

    // Decode misses and writes to DATA.
    bus_op(1'b1, 1'b0, 32'h8110, '0, v, q);
    chk("miss 8110 vld", v, 0);
    chk("miss 8110 data", q, 0);
    bus_op(1'b0, 1'b1, 32'h8000, 32'hFF, v, q);
    chk("miss 8000 vld", v, 0);
    bus_op(1'b0, 1'b0, BASE, '0, v, q);
    chk("no rw vld", v, 0);
    do_write(0, 32'hFF);
    rd_chk("DATA ro", 0);
    bus_op(1'b1, 1'b0, BASE + 3, '0, v, q);
    chk("addr lsb", q, {24'h0, m_data});
    bus_op(1'b1, 1'b1, BASE + 12, 32'hA5, v, q);
    chk("rw vld", v, 1);
    chk("rw data", q, 0);
    m_en = 8'hA5;
    check_all("rw");

    // Random pins, glitches and register writes.
    for (int r = 0; r < 20; r++) begin
      set_pins(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        logic [7:0] g;
        g = m_data ^ (8'h1 << $urandom_range(0, 7));
        gpio = g;
        cyc($urandom_range(1, 3));
        gpio = m_data;
        cyc(SETTLE);
      end
      case ($urandom_range(0, 3))
        0: do_write(4, $urandom);
        1: do_write(8, $urandom);
        2: do_write(12, $urandom);
        default: do_write(0, $urandom);
      endcase
      check_all("rand");
    end

    // Reset kills an in-flight response.
    bus_op(1'b1, 1'b0, BASE, '0, v, q);
    chk("inflight vld", v, 1);
    reset_n = 1'b0;
    #1;
    chk("rst kill vld", rsp_valid, 0);
    chk("rst kill irq", irq, 0);

    // Locate the fall edge via irq latency.
    coll_setup();
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 40 && !found; i++) begin
      cyc(1);
      if (irq) begin
        lat = i;
        found = 1'b1;
      end
    end
    chk("coll irq seen", found, 1);
    if (found && lat >= 3) begin
      // Clear in the same cycle as the edge.
      coll_setup();
      cyc(lat - 2);
      do_write(8, 32'h1);
      cyc(3);
      m_fall = 8'h01;
      rd_chk("coll set wins", 8);
      chk("coll irq", irq, 1);
      // Clear one cycle after the edge.
      coll_setup();
      cyc(lat - 1);
      do_write(8, 32'h1);
      cyc(3);
      m_fall = 8'h00;
      rd_chk("coll late clr", 8);
      chk("coll late irq", irq, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
